// File: rtl/tile_query_arbiter_if.sv
// Query/map bus between the tile-query requesters, the shared board-map read
// port and the arbiter.
interface tile_query_arbiter_if;
    logic        i_freeze;
    logic [4:0]  i_req;
    logic [29:0] i_req_x;
    logic [29:0] i_req_y;
    logic [5:0]  o_map_x;
    logic [5:0]  o_map_y;
    logic [7:0]  i_map_tile;
    logic [4:0]  o_gnt;
    logic [4:0]  o_rsp_valid;
    logic [7:0]  o_rsp_tile;
    logic        o_busy;

    modport slave (
        input  i_freeze, i_req, i_req_x, i_req_y, i_map_tile,
        output o_map_x, o_map_y, o_gnt, o_rsp_valid, o_rsp_tile, o_busy
    );

    modport master (
        output i_freeze, i_req, i_req_x, i_req_y, i_map_tile,
        input  o_map_x, o_map_y, o_gnt, o_rsp_valid, o_rsp_tile, o_busy
    );
endinterface

// File: rtl/tile_query_arbiter.sv
// Round-robin arbiter for five tile queries onto one board-map read port.
// TILE_ARB_PACMAN_PRIORITY_EN: requester 0 always wins; 1-4 rotate among themselves.
module tile_query_arbiter (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    tile_query_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ADDR, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  last_q, last_d;
    logic [4:0]  gnt_q, rsp_valid_q;
    logic [7:0]  tile_q;
    logic [5:0]  map_x_q, map_y_q;
    logic        oor_q;

    logic        grant;
    logic        win_vld;
    logic [2:0]  win_idx, cand;
    logic [5:0]  win_x, win_y;
    logic        win_oor;

    always_comb begin
        win_vld = 1'b0;
        win_idx = 3'd0;
        cand    = 3'd0;
`ifdef TILE_ARB_PACMAN_PRIORITY_EN
        if (bus.i_req[0]) begin
            win_vld = 1'b1;
        end else begin
            // last_q only ever holds 1..4 here, so the walk stays inside 1..4
            for (int i = 0; i < 4; i++) begin
                cand = 3'(((int'(last_q) + i) % 4) + 1);
                if (!win_vld && bus.i_req[cand]) begin
                    win_vld = 1'b1;
                    win_idx = cand;
                end
            end
        end
`else
        for (int i = 1; i <= 5; i++) begin
            cand = 3'((int'(last_q) + i) % 5);
            if (!win_vld && bus.i_req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
`endif
        win_x   = bus.i_req_x[6*win_idx +: 6];
        win_y   = bus.i_req_y[6*win_idx +: 6];
        win_oor = (win_x > 6'd27) || (win_y > 6'd35);
    end

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        last_d  = last_q;
        case (state_q)
            IDLE: if (!bus.i_freeze && win_vld) begin
                grant   = 1'b1;
                state_d = ADDR;
`ifdef TILE_ARB_PACMAN_PRIORITY_EN
                if (win_idx != 3'd0) last_d = win_idx;
`else
                last_d = win_idx;
`endif
            end
            ADDR:    state_d = WAIT;
            WAIT:    state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            last_q      <= 3'd4;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            tile_q      <= '0;
            map_x_q     <= '0;
            map_y_q     <= '0;
            oor_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            rsp_valid_q <= '0;
            if (grant) begin
                gnt_q <= 5'b00001 << win_idx;
                oor_q <= win_oor;
                // out-of-range queries leave the map port parked on its last address
                if (!win_oor) begin
                    map_x_q <= win_x;
                    map_y_q <= win_y;
                end
            end
            if (state_q == WAIT) begin
                tile_q      <= oor_q ? 8'h00 : bus.i_map_tile;
                rsp_valid_q <= gnt_q;
            end
            if (state_q == RESP) gnt_q <= '0;
        end
    end

    assign bus.o_gnt       = gnt_q;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_tile  = tile_q;
    assign bus.o_map_x     = map_x_q;
    assign bus.o_map_y     = map_y_q;
    assign bus.o_busy      = (state_q != IDLE);
endmodule

// File: doc/tile_query_arbiter.md
TILE_QUERY_ARBITER -- requirements
Module: tile_query_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous active-low reset, named as follows: i_clk input 1 (50 MHz system clock, all state on rising edge), i_rst_n input 1 (synchronous reset, active low).
REQ-002 The block SHALL provide i_freeze, input, 1 bit: when high, no new grant is issued.
REQ-003 The block SHALL provide i_req, input, 5 bits: query request per requester; bit 0 pacman, 1 blinky, 2 pinky, 3 inky, 4 clyde.
REQ-004 The block SHALL provide i_req_x, input, 30 bits: tile column per requester, 6 bits each, requester k in bits [6k+5:6k].
REQ-005 The block SHALL provide i_req_y, input, 30 bits: tile row per requester, packed the same way as i_req_x.
REQ-006 The block SHALL provide o_map_x, output, 6 bits, and o_map_y, output, 6 bits: address to the shared board-map read port.
REQ-007 The block SHALL provide i_map_tile, input, 8 bits: board-map read data, valid 1 cycle after the address.
REQ-008 The block SHALL provide o_gnt, output, 5 bits: one-hot grant, held for the whole transaction.
REQ-009 The block SHALL provide o_rsp_valid, output, 5 bits: one-hot, 1-cycle response strobe.
REQ-010 The block SHALL provide o_rsp_tile, output, 8 bits: tile value returned with o_rsp_valid.
REQ-011 The block SHALL provide o_busy, output, 1 bit: high in any state except IDLE.

Function
REQ-012 The block SHALL implement the states IDLE, ADDR, WAIT and RESP.
REQ-013 In IDLE, if i_freeze=0 and i_req!=0, the block SHALL select the winner, register o_gnt, o_map_x and o_map_y from the winner's coordinates, and go to ADDR.
REQ-014 ADDR SHALL go to WAIT unconditionally, holding the address.
REQ-015 In WAIT the block SHALL register i_map_tile into o_rsp_tile and go to RESP.
REQ-016 In RESP the block SHALL assert o_rsp_valid equal to o_gnt for exactly 1 cycle, clear o_gnt, and go to IDLE.
REQ-017 Latency SHALL be as follows: a request sampled in IDLE at edge N gives o_rsp_valid high during cycle N+3.
REQ-018 Throughput SHALL be at most one query per 4 cycles, with no back-to-back overlap.
REQ-019 Round-robin SHALL apply: a 3-bit last-grant pointer, with search starting at last+1 and wrapping from 4 to 0.
REQ-020 The last-grant pointer SHALL update only on grant.
REQ-021 Coordinates SHALL be latched at grant; changes to i_req_x or i_req_y after grant SHALL be ignored.
REQ-022 A requester dropping i_req mid-transaction SHALL NOT abort the transaction; the response is still strobed.
REQ-023 A requester SHALL hold i_req until its o_rsp_valid; a req still high in the IDLE cycle after RESP SHALL be treated as a new request.
REQ-024 Out-of-range queries (x>27 or y>35) SHALL NOT drive the map port (o_map_x/o_map_y remain at the previous value), and o_rsp_tile SHALL be 8'h00; the latency is unchanged.
REQ-025 i_freeze SHALL block only the IDLE->ADDR transition; a transaction in progress SHALL complete.
REQ-026 o_busy SHALL be driven combinationally from the state.

Reset
REQ-027 On a clock edge with i_rst_n=0, the block SHALL set state IDLE, o_gnt=0, o_rsp_valid=0, o_rsp_tile=0, o_map_x=0, o_map_y=0, and last-grant pointer=4, so that requester 0 has first priority.
REQ-028 Reset SHALL take precedence mid-transaction; the pending response SHALL be dropped with no o_rsp_valid.

Configuration
REQ-029 The block SHALL support the macro TILE_ARB_PACMAN_PRIORITY_EN.
REQ-030 When TILE_ARB_PACMAN_PRIORITY_EN is defined, i_req[0] SHALL always win if set; bits 1-4 SHALL be arbitrated round-robin among themselves, with a pointer that ignores pacman grants.
REQ-031 When TILE_ARB_PACMAN_PRIORITY_EN is undefined, the block SHALL use plain 5-way round-robin per REQ-019.

Verification
REQ-032 Single request: reset, then i_req=5'b00100, x=13, y=14, map returns 8'h3C -> o_gnt=00100 and o_map=(13,14) in cycle 1, o_rsp_valid=00100 and o_rsp_tile=8'h3C in cycle 3.
REQ-033 Contention (macro undefined): i_req=5'b11111 held -> grant order 0,1,2,3,4,0, one grant every 4 cycles.
REQ-034 Contention (macro defined): i_req=5'b10011 held -> grant order 0,0,0...; with req[0] dropped after the first grant -> 1,4,1,4.
REQ-035 Freeze: i_freeze=1 raised in ADDR -> current response still delivered; no new o_gnt until i_freeze=0.
REQ-036 Boundary: query x=28, y=5 -> o_rsp_tile=8'h00 at cycle 3 and o_map unchanged; reset asserted during WAIT -> no o_rsp_valid, all outputs 0 the next cycle.
